// File: rtl/fifo_reader_if.sv
// Handshake bundle for fifo_reader: FIFO read side, downstream ready/valid
// side, enable control and status outputs.
interface fifo_reader_if #(
  parameter int WORD_SIZE = 10,
  parameter int CNT_W     = 8
);
  logic                 enable;
  logic                 fifo_empty;
  logic [WORD_SIZE-1:0] fifo_data_out;
  logic                 fifo_rd;
  logic                 out_ready;
  logic                 out_valid;
  logic [WORD_SIZE-1:0] out_data;
  logic [CNT_W-1:0]     words_out;
  logic                 busy;

  // The reader itself: consumes FIFO data and ready, produces strobe and output
  modport master (
    input  enable, fifo_empty, fifo_data_out, out_ready,
    output fifo_rd, out_valid, out_data, words_out, busy
  );

  // The environment around the reader: FIFO plus downstream consumer
  modport slave (
    output enable, fifo_empty, fifo_data_out, out_ready,
    input  fifo_rd, out_valid, out_data, words_out, busy
  );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: pulls words out of a 1-cycle-latency FIFO into a 2-entry
// in-order output buffer and hands them downstream over ready/valid.
// Reads are credit-limited so the buffer can never overflow.
module fifo_reader #(
  parameter int WORD_SIZE = 10,
  parameter int CNT_W     = 8
) (
  input  logic          clk,
  input  logic          reset,
  fifo_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t               state;
  state_t               state_next;
  logic [1:0]           occ;
  logic                 infl;
  logic [WORD_SIZE-1:0] buf_head;
  logic [WORD_SIZE-1:0] buf_tail;
  logic                 out_valid_q;
  logic [CNT_W-1:0]     words_cnt;

  logic                 pop;
  logic                 rd;
  logic [1:0]           occ_next;
  logic [1:0]           slot;
  logic [WORD_SIZE-1:0] head_next;
  logic [WORD_SIZE-1:0] tail_next;

  assign pop = out_valid_q & bus.out_ready;

  // Buffer bookkeeping: occupancy after this edge, where the in-flight word lands,
  // and the shifted/appended buffer contents (pop and capture may coincide)
  always_comb begin
    occ_next  = occ + {1'b0, infl} - {1'b0, pop};
    slot      = occ - {1'b0, pop};
    head_next = buf_head;
    tail_next = buf_tail;
    if (pop) begin
      head_next = buf_tail;
    end
    if (infl) begin
      if (slot == 2'd0) begin
        head_next = bus.fifo_data_out;
      end else begin
        tail_next = bus.fifo_data_out;
      end
    end
  end

  // A new read is only issued when the word it returns is guaranteed a free slot
  assign rd = reset & bus.enable & ~bus.fifo_empty & (occ_next < 2'd2);

  // Next FSM state follows directly from next occupancy and next in-flight flag
  always_comb begin
    state_next = FILL;
    if (occ_next == 2'd0 && !rd) begin
      state_next = IDLE;
    end else if (occ_next == 2'd2) begin
      state_next = FULL;
    end
  end

  // All registered state; reset wipes everything, including any word in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      occ         <= 2'd0;
      infl        <= 1'b0;
      buf_head    <= '0;
      buf_tail    <= '0;
      out_valid_q <= 1'b0;
      words_cnt   <= '0;
    end else begin
      state       <= state_next;
      occ         <= occ_next;
      infl        <= rd;
      buf_head    <= head_next;
      buf_tail    <= tail_next;
      out_valid_q <= (occ_next != 2'd0);
      if (pop) begin
        words_cnt <= words_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.fifo_rd   = rd;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = buf_head;
  assign bus.words_out = words_cnt;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed vector table plus hand
// sequences for the corner cases, then randomized traffic checked by a
// count-based reference model (words read vs words delivered).
module tb_fifo_reader;

  localparam int WORD_SIZE = 10;
  localparam int CNT_W     = 8;
  localparam int MEM_DEPTH = 8192;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  fifo_reader_if #(.WORD_SIZE(WORD_SIZE), .CNT_W(CNT_W)) bus();

  fifo_reader #(.WORD_SIZE(WORD_SIZE), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: word store written by the stimulus, read pointer advanced by strobes
  logic [WORD_SIZE-1:0] fifo_mem [MEM_DEPTH];
  int   wr_ptr  = 0;
  int   rd_ptr  = 0;
  logic rd_pend = 1'b0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  // Strobe is sampled mid-cycle, away from the edge where the DUT state moves
  always @(negedge clk) rd_pend <= bus.fifo_rd;

  // FIFO returns the word one cycle after the strobe; otherwise drives junk
  always @(posedge clk) begin
    if (rd_pend && rd_ptr < wr_ptr) begin
      bus.fifo_data_out <= fifo_mem[rd_ptr];
      rd_ptr            <= rd_ptr + 1;
    end else begin
      bus.fifo_data_out <= WORD_SIZE'($urandom);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: next word owed downstream and delivered count
  int                   deliver_ptr = 0;
  int                   delivered   = 0;
  logic                 prev_rd     = 1'b0;
  logic                 prev_valid  = 1'b0;
  logic                 prev_ready  = 1'b0;
  logic [WORD_SIZE-1:0] prev_data   = '0;

  typedef struct {
    logic                 en;
    logic                 rdy;
    logic                 exp_rd;
    logic                 exp_valid;
    logic [WORD_SIZE-1:0] exp_data;
    int                   exp_words;
    logic                 exp_busy;
  } vec_t;

  vec_t stream_tbl [6];

  function automatic vec_t mkVec(input logic en, input logic rdy, input logic rd,
                                 input logic valid, input logic [WORD_SIZE-1:0] data,
                                 input int words, input logic busy);
    vec_t v;
    v.en = en; v.rdy = rdy; v.exp_rd = rd; v.exp_valid = valid;
    v.exp_data = data; v.exp_words = words; v.exp_busy = busy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    @(posedge clk);
    #1;
    bus.enable    = en;
    bus.out_ready = rdy;
  endtask

  task automatic pushWord(input logic [WORD_SIZE-1:0] v);
    if (wr_ptr < MEM_DEPTH) begin
      fifo_mem[wr_ptr] = v;
      wr_ptr++;
    end
  endtask

  task automatic doReset();
    reset         = 1'b0;
    bus.enable    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drainFifo();
    bit done;
    done = 0;
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.fifo_empty && !bus.busy && !bus.fifo_rd) done = 1;
    end
    checkOutput("drain_done", 32'(done), 32'd1);
    applyStimulus(1'b0, 1'b0);
  endtask

  // Per-cycle reference check: outstanding = words read but not yet delivered
  task automatic monitorStep();
    int   outstanding;
    logic pop;
    logic exp_rd;
    logic exp_valid;
    if (!reset) begin
      checkOutput("rst_fifo_rd",   32'(bus.fifo_rd),   32'd0);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
      checkOutput("rst_busy",      32'(bus.busy),      32'd0);
      checkOutput("rst_words_out", 32'(bus.words_out), 32'd0);
      deliver_ptr = rd_ptr;
      delivered   = 0;
      prev_rd     = 1'b0;
      prev_valid  = 1'b0;
      prev_ready  = 1'b0;
    end else begin
      outstanding = rd_ptr - deliver_ptr;
      pop         = bus.out_valid && bus.out_ready;
      exp_valid   = (outstanding - int'(prev_rd)) > 0;
      exp_rd      = bus.enable && !bus.fifo_empty && ((outstanding - (pop ? 1 : 0)) < 2);
      checkOutput("mdl_out_valid", 32'(bus.out_valid), 32'(exp_valid));
      checkOutput("mdl_busy",      32'(bus.busy),      32'(outstanding > 0));
      checkOutput("mdl_words_out", 32'(bus.words_out), 32'(delivered % (1 << CNT_W)));
      checkOutput("mdl_fifo_rd",   32'(bus.fifo_rd),   32'(exp_rd));
      checkOutput("mdl_no_overfill", 32'(outstanding <= 2), 32'd1);
      if (prev_valid && !prev_ready) begin
        checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("hold_data",  32'(bus.out_data),  32'(prev_data));
      end
      if (pop) begin
        if (deliver_ptr < MEM_DEPTH)
          checkOutput("mdl_order", 32'(bus.out_data), 32'(fifo_mem[deliver_ptr]));
        deliver_ptr++;
        delivered++;
      end
      prev_rd    = bus.fifo_rd;
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_data  = bus.out_data;
    end
  endtask

  task automatic runTests();
    logic [WORD_SIZE-1:0] w [5];
    int cnt;
    int del;
    int pops;
    bit got;
    bit seen_ff;
    bit seen_00;

    // Streaming: three preloaded words, one per cycle
    stream_tbl[0] = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 0, 1'b0);
    stream_tbl[1] = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 0, 1'b1);
    stream_tbl[2] = mkVec(1'b1, 1'b1, 1'b1, 1'b1, 10'h3FF, 0, 1'b1);
    stream_tbl[3] = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 10'h2B3, 1, 1'b1);
    stream_tbl[4] = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 10'h2B7, 2, 1'b1);
    stream_tbl[5] = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 3, 1'b0);

    doReset();
    pushWord(10'h3FF); pushWord(10'h2B3); pushWord(10'h2B7);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(stream_tbl[i].en, stream_tbl[i].rdy);
      @(negedge clk);
      checkOutput("stream_rd",    32'(bus.fifo_rd),   32'(stream_tbl[i].exp_rd));
      checkOutput("stream_valid", 32'(bus.out_valid), 32'(stream_tbl[i].exp_valid));
      if (stream_tbl[i].exp_valid)
        checkOutput("stream_data", 32'(bus.out_data), 32'(stream_tbl[i].exp_data));
      checkOutput("stream_words", 32'(bus.words_out), 32'(stream_tbl[i].exp_words));
      checkOutput("stream_busy",  32'(bus.busy),      32'(stream_tbl[i].exp_busy));
    end

    // Backpressure: five words waiting, downstream stalled
    doReset();
    for (int i = 0; i < 5; i++) begin
      w[i] = WORD_SIZE'($urandom);
      pushWord(w[i]);
    end
    applyStimulus(1'b1, 1'b0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.fifo_rd) cnt++;
    end
    checkOutput("bp_rd_pulses", 32'(cnt), 32'd2);
    checkOutput("bp_valid",     32'(bus.out_valid), 32'd1);
    checkOutput("bp_head",      32'(bus.out_data),  32'(w[0]));
    checkOutput("bp_busy",      32'(bus.busy),      32'd1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_no_gap", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_order",  32'(bus.out_data),  32'(w[i]));
    end
    @(negedge clk);
    checkOutput("bp_words", 32'(bus.words_out), 32'd5);

    // Enable drop while a read is issued
    doReset();
    for (int i = 0; i < 4; i++) begin
      w[i] = WORD_SIZE'($urandom);
      pushWord(w[i]);
    end
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    checkOutput("drop_rd_first", 32'(bus.fifo_rd), 32'd1);
    applyStimulus(1'b0, 1'b1);
    cnt = 0;
    del = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.fifo_rd) cnt++;
      if (bus.out_valid && bus.out_ready) begin
        del++;
        checkOutput("drop_data", 32'(bus.out_data), 32'(w[0]));
      end
    end
    checkOutput("drop_no_more_rd", 32'(cnt), 32'd0);
    checkOutput("drop_delivered",  32'(del), 32'd1);
    checkOutput("drop_words",      32'(bus.words_out), 32'd1);
    drainFifo();

    // Empty FIFO: nothing must happen
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      @(negedge clk);
      checkOutput("empty_rd",    32'(bus.fifo_rd),   32'd0);
      checkOutput("empty_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("empty_busy",  32'(bus.busy),      32'd0);
    end

    // Reset with one word buffered and one in flight
    doReset();
    pushWord(WORD_SIZE'($urandom)); pushWord(WORD_SIZE'($urandom));
    applyStimulus(1'b1, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("rm_words_before", 32'(bus.words_out), 32'd2);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      w[i] = WORD_SIZE'($urandom);
      pushWord(w[i]);
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rm_busy_before",  32'(bus.busy),      32'd1);
    checkOutput("rm_valid_before", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rm_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rm_words", 32'(bus.words_out), 32'd0);
    checkOutput("rm_busy",  32'(bus.busy),      32'd0);
    checkOutput("rm_rd",    32'(bus.fifo_rd),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rm_rd_after_release", 32'(bus.fifo_rd), 32'd1);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checkOutput("rm_first_word", 32'(bus.out_data), 32'(w[2]));
        got = 1;
      end
    end
    checkOutput("rm_delivery_seen", 32'(got), 32'd1);
    drainFifo();

    // Counter wrap over 256 deliveries
    doReset();
    for (int i = 0; i < 256; i++) pushWord(WORD_SIZE'($urandom));
    applyStimulus(1'b1, 1'b1);
    pops    = 0;
    seen_ff = 0;
    seen_00 = 0;
    for (int i = 0; i < 700 && !seen_00; i++) begin
      @(negedge clk);
      if (pops == 255 && !seen_ff) begin
        checkOutput("wrap_ff", 32'(bus.words_out), 32'hFF);
        seen_ff = 1;
      end
      if (pops == 256) begin
        checkOutput("wrap_00", 32'(bus.words_out), 32'h00);
        seen_00 = 1;
      end
      if (bus.out_valid && bus.out_ready) pops++;
    end
    checkOutput("wrap_completed", 32'(seen_ff && seen_00), 32'd1);

    // Randomized traffic with sporadic refills and resets
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 3) == 0 && wr_ptr < MEM_DEPTH - 4) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) pushWord(WORD_SIZE'($urandom));
      end
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
      end
    end
    applyStimulus(1'b0, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("final_outstanding", 32'(rd_ptr - deliver_ptr), 32'd0);
    checkOutput("final_busy",        32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.out_ready = 1'b0;
    fork
      begin
        forever begin
          @(negedge clk);
          monitorStep();
        end
      end
      begin
        runTests();
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
